kbd_input_fifo: RTL and testbench
=================================

Name: kbd_input_fifo

Overview:
- Keyboard input stage directly upstream of the accumulator CPU's input register (INPR/FGI) in tt_um_LnL_SoC.
- Samples the 8-bit keyboard bus (ui_in) on each rising edge of the asynchronous key strobe (uio_in[0]) and queues the bytes in a small FIFO.
- Presents the head byte plus an input-ready flag to the CPU; the CPU's INP execution pops one entry.
- Back-to-back keystrokes are not lost while the CPU is inside an interrupt service routine.

Parameters:
- DATA_W, 8, keyboard byte width.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- SYNC_STAGES, 2, synchroniser flops on the strobe; at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  block enable (TT ena); 0 freezes push and pop.
- kbd_data  input  DATA_W  keyboard byte (ui_in); must be stable while kbd_strobe is high.
- kbd_strobe  input  1  asynchronous key strobe (uio_in[0]); the rising edge marks a new byte.
- cpu_rd  input  1  one-cycle pulse from the CPU on INP execution; pops the head entry.
- clr_ovf  input  1  one-cycle pulse; clears ovf.
- inpr  output  DATA_W  head byte; 0 when empty.
- fgi  output  1  input flag; 1 when the FIFO is not empty; drives the CPU interrupt request.
- ovf  output  1  sticky flag: a byte was dropped because the FIFO was full.
- count  output  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Pointers, count, ovf, the synchroniser chain and the armed flag go to 0.
  - inpr=0, fgi=0.
  - Reset mid-operation discards all queued bytes.
- Strobe path: SYNC_STAGES-flop synchroniser, then a rising-edge detector.
  - The detector is armed only after the synchronised strobe has been seen low once after reset, so a strobe held high through reset produces no push.
- Push: a push occurs in the cycle the synchronised rising edge is detected and ena=1.
  - The byte is kbd_data registered at that same clk edge.
- Latency: kbd_strobe rising at the input sets fgi after SYNC_STAGES+1 clk edges (3 by default).
  - When the FIFO was empty, inpr shows the new byte on the same edge fgi rises.
- Pop: cpu_rd=1, ena=1 and count>0 advance the read pointer.
  - inpr/fgi reflect the new head on the next edge.
  - cpu_rd with count=0 is ignored, with no state change.
- One push per strobe edge. Holding the strobe high gives no repeat push; the next push needs the strobe to go low for at least one synchronised cycle.
- Full (count=DEPTH):
  - Push without pop: byte dropped, ovf set, contents unchanged.
  - Push and pop in the same cycle: both take effect, count stays DEPTH, no ovf.
- Empty with push and pop in the same cycle: the pop is ignored and the push takes effect, so count becomes 1.
- Pointer arithmetic is modulo DEPTH; wrap-around is transparent.
- count is saturating by construction and never exceeds DEPTH.
- ovf: once set it stays set until clr_ovf=1 or reset. If a set and a clear happen in the same cycle, set wins.
- ena=0: no push, no pop, no ovf change. The synchroniser and edge detector keep running, and edges seen while ena=0 are discarded, not deferred.
- inpr is driven from a register or from FIFO storage muxed by the read pointer; there is no combinational path from kbd_data to inpr.

Decomposition:
- Package kbd_pkg holds:
  - KBD_DATA_W = 8 and KBD_DEPTH = 4.
  - KBD_PTR_W = clog2(KBD_DEPTH).
  - The count width, KBD_PTR_W+1.
- Sub-module sync_edge: SYNC_STAGES synchroniser, armed flag and rising-edge pulse output. It is reusable for the uio SPI chip-select.

Test Plan:
- Reset then single key: kbd_data=0x77, strobe high for 5 cycles (clk 100 ns) -> fgi=1 and inpr=0x77 exactly 3 edges after the strobe rises, count=1; cpu_rd pulse -> fgi=0, inpr=0x00, count=0.
- Burst and order: strobe edges with 0x77, 0x66, 0x55, 0x44 and no reads -> count=4, ovf=0; four cpu_rd pulses -> inpr sequence 0x77, 0x66, 0x55, 0x44, then fgi=0.
- Overflow: fill to 4, then a fifth strobe with 0x33 -> byte dropped, ovf=1, head still 0x77; clr_ovf pulse -> ovf=0; a set and a clear in the same cycle -> ovf=1.
- Full with simultaneous push and pop: count=4, cpu_rd aligned with the detected edge of 0x22 -> count=4, ovf=0; draining yields 0x66, 0x55, 0x44, 0x22.
- Reset corner cases:
  - Strobe held high through rst_n release -> no push, count=0.
  - Strobe low then high -> exactly one push.
  - rst_n asserted with count=3 -> count=0, fgi=0 on that edge.
- Enable and empty read: ena=0 during a strobe edge with 0x11 -> no push; cpu_rd with count=0 -> count stays 0, no underflow, pointers unchanged.

Source files
------------

// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Shared sizing constants for the keyboard input FIFO slice.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    localparam int KBD_DATA_W      = 8;
    localparam int KBD_DEPTH       = 4;
    localparam int KBD_SYNC_STAGES = 2;
    localparam int KBD_PTR_W       = $clog2(KBD_DEPTH);
    localparam int KBD_CNT_W       = KBD_PTR_W + 1;

endpackage : kbd_pkg
`default_nettype wire

// File: rtl/kbd_input_fifo_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Multi-flop synchroniser for an asynchronous strobe followed by
//               an armed rising-edge detector. The detector only fires after
//               a genuine low has been observed since reset, so a strobe held
//               high through reset never produces a pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge
    import kbd_pkg::*;
#(
    parameter int SYNC_STAGES = KBD_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    // Marks which synchroniser stages hold a real sample taken after reset,
    // as opposed to the reset zero.
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   prev_q;
    logic                   armed_q;

    // Synchroniser chain, post-reset validity shadow, history bit and arming.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            vld_q   <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (vld_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
                armed_q <= 1'b1;
            end
        end
    end

    // One-cycle pulse on a synchronised low-to-high transition once armed.
    always_comb begin
        rise_o = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
    end

endmodule : sync_edge
`default_nettype wire

// File: rtl/kbd_input_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kbd_input_fifo
// Description : Keyboard input stage feeding the CPU INPR/FGI register. Each
//               synchronised rising edge of the key strobe queues the keyboard
//               byte; a CPU INP read pops the head entry. Full pushes are
//               dropped and flagged in a sticky overflow bit.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_input_fifo
    import kbd_pkg::*;
#(
    parameter int DATA_W      = KBD_DATA_W,
    parameter int DEPTH       = KBD_DEPTH,
    parameter int SYNC_STAGES = KBD_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [DATA_W-1:0]        kbd_data,
    input  logic                     kbd_strobe,
    input  logic                     cpu_rd,
    input  logic                     clr_ovf,
    output logic [DATA_W-1:0]        inpr,
    output logic                     fgi,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic              strobe_rise;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (kbd_strobe),
        .rise_o  (strobe_rise)
    );

    // Push/pop qualification: a full FIFO still accepts a push when the head
    // is popped in the same cycle; a pop on an empty FIFO is ignored.
    always_comb begin
        full  = (count_q == C_FULL);
        empty = (count_q == '0);
        pop   = ena & cpu_rd & ~empty;
        push  = ena & strobe_rise & (~full | pop);
        drop  = ena & strobe_rise & full & ~pop;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ena && clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Byte storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= kbd_data;
        end
    end

    // Head byte is masked to zero when empty so the CPU never sees stale data.
    always_comb begin
        inpr  = empty ? '0 : mem_q[rd_ptr_q];
        fgi   = ~empty;
        ovf   = ovf_q;
        count = count_q;
    end

endmodule : kbd_input_fifo
`default_nettype wire

// File: tb/tb_kbd_input_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_input_fifo
// Description : Directed self-checking bench for kbd_input_fifo with a
//               queue-based reference model compared on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_input_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_strobe = 1'b0;
    logic       cpu_rd = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] inpr;
    logic       fgi;
    logic       ovf;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    kbd_input_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .kbd_data   (kbd_data),
        .kbd_strobe (kbd_strobe),
        .cpu_rd     (cpu_rd),
        .clr_ovf    (clr_ovf),
        .inpr       (inpr),
        .fgi        (fgi),
        .ovf        (ovf),
        .count      (count)
    );

    always #50 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: strobe samples taken at each clock edge since reset.
    // A push at edge n needs the sample from two edges earlier to be high and
    // the one before it to be a genuine post-reset low.
    bit       hist[$];
    bit [7:0] mq[$];
    bit       m_ovf   = 1'b0;
    bit       m_valid = 1'b0;

    always @(posedge clk) begin
        int  n;
        bit  rise, push, pop, drop;
        if (!rst_n) begin
            hist.delete();
            mq.delete();
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            hist.push_back(kbd_strobe);
            n    = hist.size();
            rise = (n >= 4) && hist[n-3] && !hist[n-4];
            pop  = ena && cpu_rd && (mq.size() > 0);
            push = ena && rise;
            drop = push && (mq.size() == DEPTH) && !pop;
            if (drop) begin
                m_ovf = 1'b1;
            end else begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(kbd_data);
                if (ena && clr_ovf) m_ovf = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_inpr",  int'(inpr),  (mq.size() > 0) ? int'(mq[0]) : 0);
            chk("model_fgi",   int'(fgi),   (mq.size() > 0) ? 1 : 0);
            chk("model_ovf",   int'(ovf),   int'(m_ovf));
            chk("model_count", int'(count), mq.size());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b);
        kbd_data   = b;
        kbd_strobe = 1'b1;
        cyc(3);
        kbd_strobe = 1'b0;
        cyc(3);
    endtask

    task automatic pop1();
        cpu_rd = 1'b1;
        cyc(1);
        cpu_rd = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [4];
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        chk("reset_count", int'(count), 0);
        chk("reset_fgi",   int'(fgi),   0);
        chk("reset_inpr",  int'(inpr),  0);

        // Single key and its exact latency.
        kbd_data   = 8'h77;
        kbd_strobe = 1'b1;
        cyc(2);
        chk("latency_fgi_early", int'(fgi), 0);
        cyc(1);
        chk("latency_fgi",  int'(fgi),   1);
        chk("latency_inpr", int'(inpr),  8'h77);
        chk("single_count", int'(count), 1);
        cyc(2);
        kbd_strobe = 1'b0;
        cyc(3);
        chk("hold_no_repeat", int'(count), 1);
        pop1();
        chk("pop_fgi",   int'(fgi),   0);
        chk("pop_inpr",  int'(inpr),  0);
        chk("pop_count", int'(count), 0);

        // Burst ordering.
        seq = '{8'h77, 8'h66, 8'h55, 8'h44};
        for (int i = 0; i < 4; i++) key(seq[i]);
        chk("burst_count", int'(count), 4);
        chk("burst_ovf",   int'(ovf),   0);
        for (int i = 0; i < 4; i++) begin
            chk("burst_order", int'(inpr), int'(seq[i]));
            pop1();
        end
        chk("burst_empty_fgi", int'(fgi), 0);

        // Overflow, clear, and set-wins-over-clear.
        for (int i = 0; i < 4; i++) key(seq[i]);
        key(8'h33);
        chk("ovf_set",   int'(ovf),   1);
        chk("ovf_head",  int'(inpr),  8'h77);
        chk("ovf_count", int'(count), 4);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("ovf_clr", int'(ovf), 0);
        kbd_data   = 8'h35;
        kbd_strobe = 1'b1;
        cyc(2);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("ovf_set_wins", int'(ovf), 1);
        kbd_strobe = 1'b0;
        cyc(3);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;

        // Full FIFO with push and pop in the same cycle.
        kbd_data   = 8'h22;
        kbd_strobe = 1'b1;
        cyc(2);
        cpu_rd = 1'b1;
        cyc(1);
        cpu_rd = 1'b0;
        chk("full_pp_count", int'(count), 4);
        chk("full_pp_ovf",   int'(ovf),   0);
        kbd_strobe = 1'b0;
        cyc(3);
        seq = '{8'h66, 8'h55, 8'h44, 8'h22};
        for (int i = 0; i < 4; i++) begin
            chk("full_pp_drain", int'(inpr), int'(seq[i]));
            pop1();
        end
        chk("full_pp_empty", int'(count), 0);

        // Strobe held high through reset release.
        kbd_strobe = 1'b1;
        rst_n      = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(6);
        chk("held_through_reset", int'(count), 0);
        kbd_strobe = 1'b0;
        cyc(3);
        kbd_data   = 8'hA5;
        kbd_strobe = 1'b1;
        cyc(5);
        kbd_strobe = 1'b0;
        cyc(3);
        chk("rearm_one_push", int'(count), 1);
        chk("rearm_inpr",     int'(inpr),  8'hA5);
        key(8'h01);
        key(8'h02);
        chk("pre_reset_count", int'(count), 3);
        rst_n = 1'b0;
        cyc(1);
        chk("mid_reset_count", int'(count), 0);
        chk("mid_reset_fgi",   int'(fgi),   0);
        rst_n = 1'b1;
        cyc(4);

        // Enable low discards edges; empty read has no effect.
        ena = 1'b0;
        key(8'h11);
        ena = 1'b1;
        cyc(2);
        chk("ena_off_nopush", int'(count), 0);
        pop1();
        chk("empty_rd_count", int'(count), 0);
        chk("empty_rd_fgi",   int'(fgi),   0);
        key(8'h12);
        chk("after_empty_rd_inpr",  int'(inpr),  8'h12);
        chk("after_empty_rd_count", int'(count), 1);
        pop1();
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_kbd_input_fifo
`default_nettype wire
